csr_dbg_arbiter: RTL and testbench

- Shares the machine-mode CSR access port (address, write value, write strobe, read value) between the pipeline M stage and a debug-module abstract-command requester.
- Debug requests are accepted through a valid/ready handshake.
- The block stalls the pipeline, waits for the M stage to drain of CSR instructions, performs one read-then-optional-write, and returns the read data and an error flag through a valid/ready response channel.
- It sits between the privileged-unit CSR decode and the machine CSR file.

---
 rtl/csr_dbg_arbiter_pkg.sv | 19 +
 rtl/csr_dbg_timeout.sv | 28 ++
 rtl/flopenr.sv | 17 +
 rtl/csr_dbg_arbiter.sv | 126 ++++++++++++
 tb/tb_csr_dbg_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_dbg_arbiter_pkg.sv
// Shared types for the debug/pipeline CSR port arbiter.
// State encoding and timeout counter sizing.
package csr_dbg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    ACCESS,
    RESP
  } csr_dbg_state_t;

  localparam int DBG_TIMEOUT_DEF = 255;
  localparam int DBG_CNT_W_DEF   = $clog2(DBG_TIMEOUT_DEF + 1);

  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/csr_dbg_timeout.sv
// Saturating DRAIN-cycle counter for the CSR debug arbiter.
// expired flags the enabled cycle whose increment reaches TIMEOUT.
module csr_dbg_timeout
  import csr_dbg_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DBG_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = cnt_width(TIMEOUT);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == W'(TIMEOUT)) ? cnt : cnt + W'(1);
  assign expired = en & (cnt_nxt == W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset)
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt_nxt;

endmodule

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-low clear.
// Shared storage primitive.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset)
    if (!reset)  q <= '0;
    else if (en) q <= d;

endmodule

// File: rtl/csr_dbg_arbiter.sv
// Shares the machine CSR port between the M stage and debug commands.
// Stall, drain, one read-then-write access, then a held response.
module csr_dbg_arbiter
  import csr_dbg_arbiter_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = DBG_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            DbgReqValid,
  output logic            DbgReqReady,
  input  logic            DbgReqWrite,
  input  logic [11:0]     DbgReqAdr,
  input  logic [XLEN-1:0] DbgReqWData,
  output logic            DbgRspValid,
  input  logic            DbgRspReady,
  output logic [XLEN-1:0] DbgRspRData,
  output logic            DbgRspErr,
  input  logic            PipeCSRWriteM,
  input  logic [11:0]     PipeCSRAdrM,
  input  logic [XLEN-1:0] PipeCSRWriteValM,
  input  logic            PipeIdleM,
  output logic            PipeStallReq,
  output logic [11:0]     CSRAdrM,
  output logic [XLEN-1:0] CSRWriteValM,
  output logic            CSRMWriteM,
  input  logic [XLEN-1:0] CSRReadValM,
  input  logic            IllegalCSRAccessM,
  output logic            DbgOwner
);

  csr_dbg_state_t state;

  logic            accept;
  logic            expired;
  logic            drain_busy;
  logic            rsp_en;
  logic            cmd_write;
  logic [11:0]     cmd_adr;
  logic [XLEN-1:0] cmd_wdata;
  logic [XLEN:0]   rsp_d;
  logic            own_q;
  logic            stall_q;
  logic            rsp_vld_q;

  assign DbgReqReady = reset & (state == IDLE);
  assign accept      = DbgReqReady & DbgReqValid;
  assign drain_busy  = (state == DRAIN) & ~PipeIdleM;

  flopenr #(.WIDTH(13 + XLEN)) u_cmd (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     ({DbgReqWrite, DbgReqAdr, DbgReqWData}),
    .q     ({cmd_write, cmd_adr, cmd_wdata})
  );

  csr_dbg_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (drain_busy),
    .expired (expired)
  );

  // A timeout abort records Err=1 with zero data and never touches the CSR file
  assign rsp_en = own_q | expired;
  assign rsp_d  = own_q ? {IllegalCSRAccessM, CSRReadValM}
                        : {1'b1, {XLEN{1'b0}}};

  flopenr #(.WIDTH(XLEN + 1)) u_rsp (
    .clk   (clk),
    .reset (reset),
    .en    (rsp_en),
    .d     (rsp_d),
    .q     ({DbgRspErr, DbgRspRData})
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      own_q     <= 1'b0;
      stall_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (DbgReqValid) begin
            state   <= DRAIN;
            stall_q <= 1'b1;
          end
        DRAIN:
          if (PipeIdleM) begin
            state <= ACCESS;
            own_q <= 1'b1;
          end else if (expired) begin
            state     <= RESP;
            stall_q   <= 1'b0;
            rsp_vld_q <= 1'b1;
          end
        ACCESS: begin
          state     <= RESP;
          own_q     <= 1'b0;
          stall_q   <= 1'b0;
          rsp_vld_q <= 1'b1;
        end
        RESP:
          if (DbgRspReady) begin
            state     <= IDLE;
            rsp_vld_q <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end

  assign DbgRspValid  = rsp_vld_q;
  assign PipeStallReq = stall_q;
  assign DbgOwner     = own_q;

  assign CSRAdrM      = own_q ? cmd_adr : PipeCSRAdrM;
  assign CSRWriteValM = own_q ? cmd_wdata : PipeCSRWriteValM;
  assign CSRMWriteM   = own_q ? (cmd_write & ~IllegalCSRAccessM)
                              : PipeCSRWriteM;

endmodule

// File: tb/tb_csr_dbg_arbiter.sv
// Self-checking bench for csr_dbg_arbiter.
// Expected responses are queued at request time and popped on DbgRspValid.
module tb_csr_dbg_arbiter;

  localparam int XLEN = 64;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            DbgReqValid;
  logic            DbgReqReady;
  logic            DbgReqWrite;
  logic [11:0]     DbgReqAdr;
  logic [XLEN-1:0] DbgReqWData;
  logic            DbgRspValid;
  logic            DbgRspReady;
  logic [XLEN-1:0] DbgRspRData;
  logic            DbgRspErr;
  logic            PipeCSRWriteM;
  logic [11:0]     PipeCSRAdrM;
  logic [XLEN-1:0] PipeCSRWriteValM;
  logic            PipeIdleM;
  logic            PipeStallReq;
  logic [11:0]     CSRAdrM;
  logic [XLEN-1:0] CSRWriteValM;
  logic            CSRMWriteM;
  logic [XLEN-1:0] CSRReadValM;
  logic            IllegalCSRAccessM;
  logic            DbgOwner;

  csr_dbg_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .DbgReqValid       (DbgReqValid),
    .DbgReqReady       (DbgReqReady),
    .DbgReqWrite       (DbgReqWrite),
    .DbgReqAdr         (DbgReqAdr),
    .DbgReqWData       (DbgReqWData),
    .DbgRspValid       (DbgRspValid),
    .DbgRspReady       (DbgRspReady),
    .DbgRspRData       (DbgRspRData),
    .DbgRspErr         (DbgRspErr),
    .PipeCSRWriteM     (PipeCSRWriteM),
    .PipeCSRAdrM       (PipeCSRAdrM),
    .PipeCSRWriteValM  (PipeCSRWriteValM),
    .PipeIdleM         (PipeIdleM),
    .PipeStallReq      (PipeStallReq),
    .CSRAdrM           (CSRAdrM),
    .CSRWriteValM      (CSRWriteValM),
    .CSRMWriteM        (CSRMWriteM),
    .CSRReadValM       (CSRReadValM),
    .IllegalCSRAccessM (IllegalCSRAccessM),
    .DbgOwner          (DbgOwner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int          lat;
    int          wr;
    int          own;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int wr_seen = 0;
  int own_seen = 0;
  logic [11:0] wr_adr = '0;
  logic [63:0] wr_val = '0;

  always @(negedge clk)
    if (reset) begin
      if (CSRMWriteM) begin
        wr_seen++;
        wr_adr = CSRAdrM;
        wr_val = CSRWriteValM;
      end
      if (DbgOwner) own_seen++;
    end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic wr, input logic [63:0] rv,
                                 input logic ill, input int lo);
    exp_t e;
    if (lo >= TO) begin
      e.rd = '0; e.err = 1'b1; e.lat = TO; e.wr = 0; e.own = 0;
    end else begin
      e.rd = rv; e.err = ill; e.lat = 2 + lo;
      e.wr = (wr && !ill) ? 1 : 0; e.own = 1;
    end
    return e;
  endfunction

  task automatic do_cmd(input string tag, input logic wr,
                        input logic [11:0] adr, input logic [63:0] wd,
                        input logic [63:0] rv, input logic ill,
                        input int lo);
    exp_t e;
    int lat, left, w0, o0;
    exp_q.push_back(model(wr, rv, ill, lo));
    CSRReadValM = rv;
    IllegalCSRAccessM = ill;
    DbgReqWrite = wr;
    DbgReqAdr = adr;
    DbgReqWData = wd;
    DbgReqValid = 1'b1;
    left = lo;
    PipeIdleM = (left == 0);
    w0 = wr_seen;
    o0 = own_seen;
    chk({tag, "_rdy"}, DbgReqReady, 1);
    @(posedge clk); #1;
    DbgReqValid = 1'b0;
    chk({tag, "_stall"}, PipeStallReq, 1);
    lat = 0;
    while (!DbgRspValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (left > 0) left--;
      PipeIdleM = (left == 0);
    end
    e = exp_q.pop_front();
    chk({tag, "_vld"}, DbgRspValid, 1);
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_rd"}, DbgRspRData, e.rd);
    chk({tag, "_err"}, DbgRspErr, e.err);
    chk({tag, "_wr"}, wr_seen - w0, e.wr);
    chk({tag, "_own"}, own_seen - o0, e.own);
    PipeIdleM = 1'b1;
    if (DbgRspReady) begin
      @(posedge clk); #1;
      chk({tag, "_done"}, DbgRspValid, 0);
      chk({tag, "_idle"}, DbgReqReady, 1);
    end
  endtask

  initial begin
    reset = 1'b0;
    DbgReqValid = 1'b0;
    DbgReqWrite = 1'b0;
    DbgReqAdr = '0;
    DbgReqWData = '0;
    DbgRspReady = 1'b1;
    PipeCSRWriteM = 1'b0;
    PipeCSRAdrM = '0;
    PipeCSRWriteValM = '0;
    PipeIdleM = 1'b1;
    CSRReadValM = '0;
    IllegalCSRAccessM = 1'b0;

    #12;
    chk("rst_vld", DbgRspValid, 0);
    chk("rst_err", DbgRspErr, 0);
    chk("rst_rd", DbgRspRData, 0);
    chk("rst_stall", PipeStallReq, 0);
    chk("rst_own", DbgOwner, 0);
    #5 reset = 1'b1;
    @(posedge clk); #1;

    PipeCSRWriteM = 1'b1;
    PipeCSRAdrM = 12'h340;
    PipeCSRWriteValM = 64'd5;
    #1;
    chk("pt_we", CSRMWriteM, 1);
    chk("pt_adr", CSRAdrM, 12'h340);
    chk("pt_val", CSRWriteValM, 64'd5);
    chk("pt_own", DbgOwner, 0);
    PipeCSRWriteM = 1'b0;
    @(posedge clk); #1;

    do_cmd("rd", 1'b0, 12'h340, 64'h0, 64'hDEAD_BEEF, 1'b0, 0);
    do_cmd("wrd", 1'b1, 12'h305, 64'h8000_0001, 64'h100, 1'b0, 3);
    chk("wrd_adr", wr_adr, 12'h305);
    chk("wrd_val", wr_val, 64'h8000_0001);
    do_cmd("ill", 1'b1, 12'hF11, 64'h1234, 64'h77, 1'b1, 0);
    do_cmd("to", 1'b1, 12'h300, 64'h55, 64'h99, 1'b0, 100);
    do_cmd("to_edge", 1'b0, 12'h341, 64'h0, 64'h42, 1'b0, TO);

    DbgRspReady = 1'b0;
    do_cmd("bp", 1'b0, 12'h300, 64'h0, 64'hCAFE, 1'b0, 1);
    CSRReadValM = 64'h1111;
    PipeCSRWriteM = 1'b1;
    PipeCSRAdrM = 12'h123;
    PipeCSRWriteValM = 64'hABC;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rd", DbgRspRData, 64'hCAFE);
      chk("bp_vld", DbgRspValid, 1);
      chk("bp_rdy", DbgReqReady, 0);
      chk("bp_stall", PipeStallReq, 0);
      chk("bp_adr", CSRAdrM, 12'h123);
    end
    #2 reset = 1'b0;
    #1;
    chk("arst_vld", DbgRspValid, 0);
    chk("arst_err", DbgRspErr, 0);
    chk("arst_rd", DbgRspRData, 0);
    chk("arst_stall", PipeStallReq, 0);
    chk("arst_own", DbgOwner, 0);
    @(negedge clk);
    reset = 1'b1;
    PipeCSRWriteM = 1'b0;
    DbgRspReady = 1'b1;
    @(posedge clk); #1;
    chk("post_rdy", DbgReqReady, 1);
    chk("post_vld", DbgRspValid, 0);

    do_cmd("again", 1'b1, 12'h340, 64'h9, 64'h3, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
